// File: rtl/reconf_ib_lut_pipe_pkg.sv
// rtl/reconf_ib_lut_pipe_pkg.sv - shared sizes and load FSM encoding for the IB lookup table
package reconf_ib_lut_pipe_pkg;

    localparam int QUAN_SIZE  = 4;
    localparam int BANK_NUM   = 8;
    localparam int ADDR_W     = 2 * QUAN_SIZE;
    localparam int BANK_SEL_W = $clog2(BANK_NUM);
    localparam int OFFS_W     = ADDR_W - BANK_SEL_W;
    localparam int ENTRY_NUM  = 1 << ADDR_W;
    localparam int BANK_DEPTH = ENTRY_NUM / BANK_NUM;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SWAP = 2'd2
    } load_state_t;

endpackage

// File: rtl/reconf_ib_lut_pipe_bank.sv
// rtl/reconf_ib_lut_pipe_bank.sv - one two-page distributed-RAM bank of the IB table
module ib_lut_bank #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 32,
    parameter int OFFS_W = 5
) (
    input  logic              clk,
    input  logic              we,
    input  logic              wr_page,
    input  logic [OFFS_W-1:0] wr_offset,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_page,
    input  logic [OFFS_W-1:0] rd_offset,
    output logic [DATA_W-1:0] rd_data
);

    // Page bit is the MSB of the word address; contents survive reset.
    logic [DATA_W-1:0] mem [2*DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[{wr_page, wr_offset}] <= wr_data;
        end
    end

    assign rd_data = mem[{rd_page, rd_offset}];

endmodule

// File: rtl/reconf_ib_lut_pipe.sv
// rtl/reconf_ib_lut_pipe.sv - double-buffered banked IB lookup table with 2-stage read pipe
module reconf_ib_lut_pipe #(
    parameter int QUAN_SIZE = reconf_ib_lut_pipe_pkg::QUAN_SIZE,
    parameter int BANK_NUM  = reconf_ib_lut_pipe_pkg::BANK_NUM
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic [QUAN_SIZE-1:0] y1,
    input  logic [QUAN_SIZE-1:0] y0,
    input  logic                 in_valid,
    output logic [QUAN_SIZE-1:0] t_c,
    output logic                 out_valid,
    input  logic                 load_start,
    input  logic                 load_abort,
    input  logic [QUAN_SIZE-1:0] load_data,
    input  logic                 load_valid,
    output logic                 load_ready,
    output logic                 load_done,
    output logic                 active_page
);
    import reconf_ib_lut_pipe_pkg::*;

    localparam int ADDR_BITS  = 2 * QUAN_SIZE;
    localparam int SEL_BITS   = $clog2(BANK_NUM);
    localparam int SEL_W      = (SEL_BITS == 0) ? 1 : SEL_BITS;
    localparam int OFFS_BITS  = ADDR_BITS - SEL_BITS;
    localparam int DEPTH      = (1 << ADDR_BITS) / BANK_NUM;

    load_state_t          state;
    logic [ADDR_BITS-1:0] wr_cnt;
    logic                 wr_en;
    logic [SEL_W-1:0]     wr_bank;
    logic [OFFS_BITS-1:0] wr_offs;

    logic [ADDR_BITS-1:0] rd_addr;
    logic                 s0_valid;
    logic                 s0_page;
    logic [SEL_W-1:0]     s0_bank;
    logic [OFFS_BITS-1:0] s0_offs;
    logic [QUAN_SIZE-1:0] bank_rd [BANK_NUM];

    // Abort has priority over a coincident handshake: nothing is written.
    assign wr_en   = (state == ST_LOAD) && load_valid && !load_abort;
    assign wr_bank = SEL_W'(wr_cnt >> OFFS_BITS);
    assign wr_offs = wr_cnt[OFFS_BITS-1:0];
    assign rd_addr = {y1, y0};

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state       <= ST_IDLE;
            wr_cnt      <= '0;
            load_ready  <= 1'b0;
            load_done   <= 1'b0;
            active_page <= 1'b0;
        end else begin
            load_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (load_start) begin
                        state      <= ST_LOAD;
                        wr_cnt     <= '0;
                        load_ready <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (load_abort) begin
                        state      <= ST_IDLE;
                        load_ready <= 1'b0;
                    end else if (load_valid) begin
                        wr_cnt <= wr_cnt + 1'b1;
                        if (wr_cnt == '1) begin
                            state      <= ST_SWAP;
                            load_ready <= 1'b0;
                            load_done  <= 1'b1;
                        end
                    end
                end
                ST_SWAP: begin
                    state       <= ST_IDLE;
                    active_page <= ~active_page;
                end
                default: begin
                    state      <= ST_IDLE;
                    load_ready <= 1'b0;
                end
            endcase
        end
    end

    // Stage 0 latches the page so in-flight reads are immune to a swap.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            s0_valid  <= 1'b0;
            s0_page   <= 1'b0;
            s0_bank   <= '0;
            s0_offs   <= '0;
            out_valid <= 1'b0;
            t_c       <= '0;
        end else begin
            s0_valid  <= in_valid;
            s0_page   <= active_page;
            s0_bank   <= SEL_W'(rd_addr >> OFFS_BITS);
            s0_offs   <= rd_addr[OFFS_BITS-1:0];
            out_valid <= s0_valid;
            if (s0_valid) begin
                t_c <= bank_rd[s0_bank];
            end
        end
    end

    for (genvar g = 0; g < BANK_NUM; g++) begin : g_bank
        ib_lut_bank #(
            .DATA_W (QUAN_SIZE),
            .DEPTH  (DEPTH),
            .OFFS_W (OFFS_BITS)
        ) u_bank (
            .clk       (sys_clk),
            .we        (wr_en && (wr_bank == SEL_W'(g))),
            .wr_page   (~active_page),
            .wr_offset (wr_offs),
            .wr_data   (load_data),
            .rd_page   (s0_page),
            .rd_offset (s0_offs),
            .rd_data   (bank_rd[g])
        );
    end

endmodule
